// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_pkg : FSM state encoding and frame constants for uart_tx_fifo.         |
// | Optional PARITY state exists only when UART_TX_PARITY_EN is defined.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package uart_pkg;

    localparam int   DATA_BITS  = 8;
    localparam int   BIT_IDX_W  = $clog2(DATA_BITS);
    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_tx_fifo_if : byte write handshake and FIFO status of uart_tx_fifo.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface uart_tx_fifo_if;
    import uart_pkg::*;

    logic                 i_wr;
    logic [DATA_BITS-1:0] i_data;
    logic                 o_full;
    logic                 o_empty_n;
    logic                 o_err;

    modport master (output i_wr, i_data, input o_full, o_empty_n, o_err);
    modport slave  (input i_wr, i_data, output o_full, o_empty_n, o_err);

endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo_buf.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_tx_fifo_buf : 2^LGFLEN-deep byte FIFO with occupancy count and a      |
// | registered overflow pulse.                                                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module uart_tx_fifo_buf
    import uart_pkg::*;
#(
    parameter int LGFLEN = 3
) (
    input  wire logic                 clk_i,
    input  wire logic                 rst_i,
    input  wire logic                 wr_i,
    input  wire logic [DATA_BITS-1:0] data_i,
    input  wire logic                 rd_i,
    output logic      [DATA_BITS-1:0] data_o,
    output logic                      full_o,
    output logic                      empty_n_o,
    output logic                      err_o
);

    localparam int                DEPTH      = 1 << LGFLEN;
    localparam logic [LGFLEN:0]   FULL_COUNT = (LGFLEN+1)'(DEPTH);

    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [LGFLEN-1:0]    wr_ptr_q;
    logic [LGFLEN-1:0]    rd_ptr_q;
    logic [LGFLEN:0]      count_q;
    logic [LGFLEN:0]      count_d;
    logic                 err_q;
    logic                 wr_ok;
    logic                 rd_ok;

    // Full is judged on the registered count, so a pop in the same cycle
    // never rescues a write that arrives while full.
    assign full_o    = (count_q == FULL_COUNT);
    assign empty_n_o = (count_q != '0);
    assign wr_ok     = wr_i && !full_o;
    assign rd_ok     = rd_i && empty_n_o;
    assign data_o    = mem_q[rd_ptr_q];
    assign err_o     = err_q;

    always_comb begin
        count_d = count_q;
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            err_q   <= wr_i && full_o;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_tx_fifo : FIFO-buffered 8N1 UART transmitter, back-to-back frames.     |
// | Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 frames).        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter logic [23:0] CLOCKS_PER_BAUD = 24'd104,
    parameter logic [3:0]  LGFLEN          = 4'd3
) (
    input  wire logic      i_clk,
    input  wire logic      i_rst,
    uart_tx_fifo_if.slave  bus,
    output logic           o_busy,
    output logic           o_uart_tx
);

    localparam logic [23:0]          BAUD_RELOAD = CLOCKS_PER_BAUD - 24'd1;
    localparam logic [BIT_IDX_W-1:0] LAST_BIT    = BIT_IDX_W'(DATA_BITS - 1);

    tx_state_e            state_q, state_d;
    logic [23:0]          baud_q, baud_d;
    logic [BIT_IDX_W-1:0] bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif
    logic                 tx_q, tx_d;
    logic                 busy_q;
    logic                 pop;
    logic                 baud_zero;
    logic [DATA_BITS-1:0] head;
    logic                 fifo_full;
    logic                 fifo_empty_n;
    logic                 fifo_err;

    uart_tx_fifo_buf #(
        .LGFLEN (int'(LGFLEN))
    ) u_buf (
        .clk_i     (i_clk),
        .rst_i     (i_rst),
        .wr_i      (bus.i_wr),
        .data_i    (bus.i_data),
        .rd_i      (pop),
        .data_o    (head),
        .full_o    (fifo_full),
        .empty_n_o (fifo_empty_n),
        .err_o     (fifo_err)
    );

    assign bus.o_full    = fifo_full;
    assign bus.o_empty_n = fifo_empty_n;
    assign bus.o_err     = fifo_err;
    assign baud_zero     = (baud_q == 24'd0);

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        pop      = 1'b0;
        case (state_q)
            IDLE: begin
                if (fifo_empty_n) begin
                    pop      = 1'b1;
                    shift_d  = head;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^head;
`endif
                    baud_d   = BAUD_RELOAD;
                    bit_d    = '0;
                    state_d  = START;
                end
            end
            START: begin
                if (baud_zero) begin
                    baud_d  = BAUD_RELOAD;
                    state_d = DATA;
                end else begin
                    baud_d  = baud_q - 24'd1;
                end
            end
            DATA: begin
                if (baud_zero) begin
                    baud_d = BAUD_RELOAD;
                    if (bit_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    baud_d = baud_q - 24'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_zero) begin
                    baud_d  = BAUD_RELOAD;
                    state_d = STOP;
                end else begin
                    baud_d  = baud_q - 24'd1;
                end
            end
`endif
            STOP: begin
                // Popping on the last stop cycle chains frames with no idle gap.
                if (baud_zero) begin
                    if (fifo_empty_n) begin
                        pop      = 1'b1;
                        shift_d  = head;
`ifdef UART_TX_PARITY_EN
                        parity_d = ^head;
`endif
                        baud_d   = BAUD_RELOAD;
                        bit_d    = '0;
                        state_d  = START;
                    end else begin
                        state_d  = IDLE;
                    end
                end else begin
                    baud_d = baud_q - 24'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_d = IDLE_LEVEL;
        case (state_q)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = parity_q;
`endif
            default: tx_d = IDLE_LEVEL;
        endcase
    end

    // Line and busy are registered from the current state, so both trail the
    // FSM by one cycle and stay aligned with each other.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
            tx_q     <= IDLE_LEVEL;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
            tx_q     <= tx_d;
            busy_q   <= (state_q != IDLE);
        end
    end

    assign o_uart_tx = tx_q;
    assign o_busy    = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_uart_tx_fifo : directed self-checking bench for uart_tx_fifo.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_uart_tx_fifo;

    localparam int CPB = 104;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FRAME_CYC = FB * CPB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    logic tx;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_mis = 0;

    logic [10:0] rx_word_q  [$];
    int          rx_start_q [$];
    bit          rx_held_q  [$];
    bit          rx_busy_q  [$];

    uart_tx_fifo_if bus ();

    uart_tx_fifo #(
        .CLOCKS_PER_BAUD (24'(CPB)),
        .LGFLEN          (4'd3)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .bus       (bus),
        .o_busy    (busy),
        .o_uart_tx (tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Line monitor: samples every cycle, records one word per frame with the
    // cycle of its first low sample; a reset discards a partial frame.
    logic [10:0] m_word;
    int          m_s;
    int          m_start;
    bit          m_act = 1'b0;
    bit          m_held;
    bit          m_busy;
    always @(negedge clk) begin
        if (rst) begin
            m_act = 1'b0;
        end else begin
            if (!m_act && tx == 1'b0) begin
                m_act = 1'b1; m_s = 0; m_word = '0;
                m_held = 1'b1; m_busy = 1'b1; m_start = cyc;
            end
            if (m_act) begin
                if (m_s % CPB == 0) m_word[m_s / CPB] = tx;
                else if (tx !== m_word[m_s / CPB]) m_held = 1'b0;
                if (busy !== 1'b1) m_busy = 1'b0;
                m_s++;
                if (m_s == FRAME_CYC) begin
                    rx_word_q.push_back(m_word);
                    rx_start_q.push_back(m_start);
                    rx_held_q.push_back(m_held);
                    rx_busy_q.push_back(m_busy);
                    m_act = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] exp_frame(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {2'b01, d, 1'b0};
`endif
    endfunction

    function automatic int start_of(input int idx);
        return (idx < rx_start_q.size()) ? rx_start_q[idx] : -1;
    endfunction

    task automatic put(input logic [7:0] d);
        bus.i_wr   = 1'b1;
        bus.i_data = d;
        @(negedge clk);
    endtask

    task automatic wait_frames(input int n, input int budget);
        int b = budget;
        while (rx_word_q.size() < n && b > 0) begin
            @(negedge clk);
            b--;
        end
        chk("frames_rcvd", 32'(rx_word_q.size() >= n), 32'd1);
    endtask

    task automatic chk_frame(input string tag, input int idx, input logic [7:0] d);
        if (idx < rx_word_q.size()) begin
            chk({tag, "_bits"}, 32'(rx_word_q[idx]), 32'(exp_frame(d)));
            chk({tag, "_held"}, 32'(rx_held_q[idx]), 32'd1);
            chk({tag, "_busy"}, 32'(rx_busy_q[idx]), 32'd1);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int base;
        int w;
        int w0;
        int errs;

        bus.i_wr   = 1'b0;
        bus.i_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_tx",      32'(tx),            32'd1);
        chk("rst_busy",    32'(busy),          32'd0);
        chk("rst_full",    32'(bus.o_full),    32'd0);
        chk("rst_empty_n", 32'(bus.o_empty_n), 32'd0);
        chk("rst_err",     32'(bus.o_err),     32'd0);
        #2 rst = 1'b0;
        @(negedge clk);

        // Single byte 0x55 from idle: latency, alternating levels, busy span.
        base = rx_word_q.size();
        w = cyc + 1;
        put(8'h55);
        bus.i_wr = 1'b0;
        wait_frames(base + 1, FRAME_CYC + 50);
        chk_frame("f55", base, 8'h55);
        chk("lat55", 32'(start_of(base) - w), 32'd2);
        repeat (3) @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_tx",   32'(tx),   32'd1);

        // Two consecutive writes chain with no idle gap.
        base = rx_word_q.size();
        w = cyc + 1;
        put(8'h41);
        put(8'h42);
        bus.i_wr = 1'b0;
        wait_frames(base + 2, 2 * FRAME_CYC + 50);
        chk_frame("f41", base, 8'h41);
        chk_frame("f42", base + 1, 8'h42);
        chk("lat41", 32'(start_of(base) - w), 32'd2);
        chk("b2b_gap", 32'(start_of(base + 1) - start_of(base)), 32'(FRAME_CYC));
        repeat (5) @(negedge clk);

        // Ten writes from reset: one pops at once, eight fill, tenth overflows.
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        base = rx_word_q.size();
        errs = 0;
        for (int k = 0; k < 10; k++) begin
            put(8'(8'h10 + k));
            if (bus.o_err) errs++;
            if (k == 7) chk("ovf_full7", 32'(bus.o_full), 32'd0);
            if (k == 8) chk("ovf_full8", 32'(bus.o_full), 32'd1);
            if (k == 9) chk("ovf_err",   32'(bus.o_err),  32'd1);
        end
        bus.i_wr = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.o_err) errs++;
        end
        chk("ovf_err_count", 32'(errs), 32'd1);
        wait_frames(base + 9, 9 * FRAME_CYC + 100);
        for (int i = 0; i < 9; i++) chk_frame($sformatf("ovf%0d", i), base + i, 8'(8'h10 + i));
        repeat (20) @(negedge clk);
        chk("ovf_nframes", 32'(rx_word_q.size() - base), 32'd9);
        chk("ovf_empty_n", 32'(bus.o_empty_n), 32'd0);
        chk("ovf_busy",    32'(busy),          32'd0);

        // Write while full in the same cycle the FSM pops: dropped, count 8->7.
        base = rx_word_q.size();
        w0 = cyc + 1;
        for (int k = 0; k < 9; k++) put(8'(8'h20 + k));
        bus.i_wr = 1'b0;
        while (cyc < w0 + FRAME_CYC) @(negedge clk);
        chk("col_full_pre", 32'(bus.o_full), 32'd1);
        put(8'hEE);
        bus.i_wr = 1'b0;
        chk("col_err",       32'(bus.o_err),     32'd1);
        chk("col_full_post", 32'(bus.o_full),    32'd0);
        chk("col_empty_n",   32'(bus.o_empty_n), 32'd1);
        @(negedge clk);
        chk("col_err_clr",   32'(bus.o_err),     32'd0);
        wait_frames(base + 9, 9 * FRAME_CYC + 100);
        for (int i = 0; i < 9; i++) chk_frame($sformatf("col%0d", i), base + i, 8'(8'h20 + i));
        repeat (20) @(negedge clk);
        chk("col_nframes", 32'(rx_word_q.size() - base), 32'd9);

        // Reset during data bit 3 of 0x00, then a clean 0xA5 frame.
        base = rx_word_q.size();
        w = cyc + 1;
        put(8'h00);
        bus.i_wr = 1'b0;
        while (cyc < w + 2 + 4 * CPB + 50) @(negedge clk);
        chk("mid_tx",   32'(tx),   32'd0);
        chk("mid_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_tx",      32'(tx),            32'd1);
        chk("arst_busy",    32'(busy),          32'd0);
        chk("arst_err",     32'(bus.o_err),     32'd0);
        chk("arst_full",    32'(bus.o_full),    32'd0);
        chk("arst_empty_n", 32'(bus.o_empty_n), 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("arst_noframe", 32'(rx_word_q.size() - base), 32'd0);
        base = rx_word_q.size();
        w = cyc + 1;
        put(8'hA5);
        bus.i_wr = 1'b0;
        wait_frames(base + 1, FRAME_CYC + 50);
        chk_frame("fA5", base, 8'hA5);
        chk("latA5", 32'(start_of(base) - w), 32'd2);
        repeat (5) @(negedge clk);

`ifdef UART_TX_PARITY_EN
        base = rx_word_q.size();
        put(8'h07);
        bus.i_wr = 1'b0;
        wait_frames(base + 1, FRAME_CYC + 50);
        chk_frame("p07", base, 8'h07);
        if (base < rx_word_q.size()) chk("par07", 32'(rx_word_q[base][9]), 32'd1);
        repeat (5) @(negedge clk);
        base = rx_word_q.size();
        put(8'h55);
        bus.i_wr = 1'b0;
        wait_frames(base + 1, FRAME_CYC + 50);
        chk_frame("p55", base, 8'h55);
        if (base < rx_word_q.size()) chk("par55", 32'(rx_word_q[base][9]), 32'd0);
        repeat (5) @(negedge clk);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
